instr_stream_encoder: RTL

- Encoder counterpart of the main opcode decoder. It accepts symbolic instruction requests (kind plus fields), packs each into a 32-bit MIPS word, and writes the words sequentially into instruction memory.
- Used as the program loader ahead of the single-cycle core, and by benches to build programs without hex files.
- Supports the same five instruction kinds the decoder recognises: R-format, lw, sw, beq, j.

---
 rtl/instr_stream_encoder_pkg.sv | 26 ++
 rtl/instr_stream_encoder_pack.sv | 35 +++
 rtl/instr_stream_encoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/instr_stream_encoder_pkg.sv
// Shared definitions for the instruction-stream encoder and the opcode decoder:
// MIPS opcodes, request kind codes and the loader state encoding.
package instr_stream_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        KIND_R   = 3'd0,
        KIND_LW  = 3'd1,
        KIND_SW  = 3'd2,
        KIND_BEQ = 3'd3,
        KIND_J   = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_stream_encoder_pack.sv
// Pure combinational packer: symbolic request fields to a 32-bit MIPS word,
// with a flag telling whether the kind code is one the decoder recognises.
module instr_pack
    import instr_stream_encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Select the field layout for each kind; unknown kinds yield a zero word.
    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        case (kind_e'(kind))
            KIND_R:   word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_LW:  word = {OP_LW, rs, rt, imm};
            KIND_SW:  word = {OP_SW, rs, rt, imm};
            KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
            KIND_J:   word = {OP_J, target};
            default: begin
                word  = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: accepts symbolic instruction requests, encodes them and
// writes the words to consecutive instruction-memory locations from word 0.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256   // must not exceed 2**ADDR_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       packed_word_s;
    logic              legal_s;
    logic              accept_s;

    instr_pack u_pack (
        .kind   (in_kind),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .word   (packed_word_s),
        .legal  (legal_s)
    );

    // A start pulse takes priority, so nothing presented alongside it is taken.
    assign in_ready = (state_q == ST_LOAD) && !start;
    assign accept_s = in_valid && in_ready;

    // Next-state, write strobe and pointer; count doubles as the write pointer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (start) begin
            state_d = ST_LOAD;
            count_d = {(ADDR_W+1){1'b0}};
        end else if (accept_s) begin
            if (legal_s) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = count_q[ADDR_W-1:0];
                mem_wdata_d = packed_word_s;
                count_d     = count_q + ONE_C;
                if (count_d == DEPTH_C) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_LOAD;
                end
            end else begin
                state_d = ST_ERR;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= {(ADDR_W+1){1'b0}};
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = (state_q == ST_FULL);
    assign err       = (state_q == ST_ERR);

endmodule
